// File: rtl/rocc_accum_unit.sv
// RoCC-style custom-instruction responder: one command at a time, operating on
// NUM_ACC private 64-bit accumulators, with a shift-add multiplier for MAC.
module rocc_accum_unit #(
    parameter int NUM_ACC        = 8,
    parameter int BITS_PER_CYCLE = 4,
    parameter int TRANS_ID_BITS  = 3    // matches ariane_pkg::TRANS_ID_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [31:0]              cmd_instr_i,
    input  logic [63:0]              cmd_rs1_i,
    input  logic [63:0]              cmd_rs2_i,
    input  logic [TRANS_ID_BITS-1:0] cmd_trans_id_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [63:0]              resp_data_o,
    output logic [TRANS_ID_BITS-1:0] resp_trans_id_o,
    output logic                     busy_o
);

    localparam int STEPS  = 64 / BITS_PER_CYCLE;
    localparam int STEP_W = $clog2(STEPS) + 1;

    localparam logic [6:0] F_WRITE = 7'd0;
    localparam logic [6:0] F_READ  = 7'd1;
    localparam logic [6:0] F_ACCUM = 7'd2;
    localparam logic [6:0] F_MAC   = 7'd3;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t                     r_state, w_state_n;
    logic [63:0]                r_acc [NUM_ACC];
    logic [2:0]                 r_idx;
    logic [TRANS_ID_BITS-1:0]   r_trans_id;
    logic [63:0]                r_mcand, r_mplier, r_prod;
    logic [STEP_W-1:0]          r_step;
    logic [63:0]                r_resp_data;
    logic                       r_wr_en;
    logic [63:0]                r_wr_data;

    logic [6:0]                 w_funct7;
    logic [2:0]                 w_idx;
    logic                       w_idx_ok, w_is_mac, w_accept, w_resp_fire, w_last_step;
    logic [63:0]                w_cmd_acc, w_exec_acc;
    logic [63:0]                w_cmd_result, w_cmd_wr_data;
    logic                       w_cmd_wr_en;
    logic [63:0]                w_chunk_prod, w_prod_next;

    assign w_funct7    = cmd_instr_i[31:25];
    assign w_idx       = cmd_instr_i[14:12];
    assign w_idx_ok    = int'(w_idx) < NUM_ACC;
    assign w_is_mac    = w_idx_ok && (w_funct7 == F_MAC);

    assign cmd_ready_o  = (r_state == S_IDLE) & ~flush_i;
    assign resp_valid_o = (r_state == S_RESP) & ~flush_i;
    assign busy_o       = (r_state != S_IDLE);
    assign w_accept     = cmd_valid_i & cmd_ready_o;
    assign w_resp_fire  = resp_valid_o & resp_ready_i;

    assign resp_data_o     = r_resp_data;
    assign resp_trans_id_o = r_trans_id;

    // Accumulator read ports: one for the incoming command, one for the MAC in flight.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_cmd_acc  = '0;
        w_exec_acc = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (w_idx == 3'(i)) w_cmd_acc  = r_acc[i];
            if (r_idx == 3'(i)) w_exec_acc = r_acc[i];
        end
    end

    always_comb begin
        w_cmd_result  = '0;
        w_cmd_wr_en   = 1'b0;
        w_cmd_wr_data = '0;
        if (w_idx_ok) begin
            case (w_funct7)
                F_WRITE: begin
                    w_cmd_result  = w_cmd_acc;
                    w_cmd_wr_en   = 1'b1;
                    w_cmd_wr_data = cmd_rs1_i;
                end
                F_READ:  w_cmd_result = w_cmd_acc;
                F_ACCUM: begin
                    w_cmd_result  = w_cmd_acc + cmd_rs1_i;
                    w_cmd_wr_en   = 1'b1;
                    w_cmd_wr_data = w_cmd_acc + cmd_rs1_i;
                end
                F_MAC:   w_cmd_wr_en = 1'b1;   // value arrives at the end of EXEC
                default: ;
            endcase
        end
    end

    // Multiplicand is pre-shifted, so each chunk product is already at its bit position.
    assign w_chunk_prod = r_mcand * 64'(r_mplier[BITS_PER_CYCLE-1:0]);
    assign w_prod_next  = r_prod + w_chunk_prod;
    assign w_last_step  = (r_step == STEP_W'(STEPS - 1));

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_n = w_is_mac ? S_EXEC : S_RESP;
            S_EXEC: begin
                if (flush_i)          w_state_n = S_IDLE;
                else if (w_last_step) w_state_n = S_RESP;
            end
            S_RESP: if (flush_i || resp_ready_i) w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_n;
    end

    // NOTE: the accumulator array is reset explicitly because reset must clear architectural state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
            r_idx       <= '0;
            r_trans_id  <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prod      <= '0;
            r_step      <= '0;
            r_resp_data <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
        end else begin
            if (w_accept) begin
                r_idx       <= w_idx;
                r_trans_id  <= cmd_trans_id_i;
                r_mcand     <= cmd_rs1_i;
                r_mplier    <= cmd_rs2_i;
                r_prod      <= '0;
                r_step      <= '0;
                r_resp_data <= w_cmd_result;
                r_wr_en     <= w_cmd_wr_en;
                r_wr_data   <= w_cmd_wr_data;
            end

            if (r_state == S_EXEC) begin
                r_mcand  <= r_mcand << BITS_PER_CYCLE;
                r_mplier <= r_mplier >> BITS_PER_CYCLE;
                r_prod   <= w_prod_next;
                r_step   <= r_step + 1'b1;
                if (w_last_step) begin
                    r_resp_data <= w_exec_acc + w_prod_next;
                    r_wr_data   <= w_exec_acc + w_prod_next;
                end
            end

            // A flush abandons the pending write; a handshake commits it.
            if (flush_i && r_state != S_IDLE) begin
                r_wr_en <= 1'b0;
            end else if (w_resp_fire) begin
                r_wr_en <= 1'b0;
                if (r_wr_en) begin
                    for (int i = 0; i < NUM_ACC; i++)
                        if (r_idx == 3'(i)) r_acc[i] <= r_wr_data;
                end
            end
        end
    end

endmodule
